// File: rtl/mmio_pkg.sv
// Shared addresses, store width codes and status bit layout for the MMIO
// peripherals that sit beside the data memory.
package mmio_pkg;

  localparam logic [31:0] MMIO_TRIG_ADDR   = 32'h0000_00FC;
  localparam logic [31:0] MMIO_OUT_ADDR    = 32'h0000_00F8;
  localparam logic [31:0] MMIO_STATUS_ADDR = 32'h0000_00F4;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_W  = 4;

endpackage

// File: rtl/mmio_out_port_sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; a pop frees a slot
// for a push in the same cycle, so full+push+pop is accepted.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mmio_out_port.sv
// Store-side MMIO output port: CPU stores push into a FIFO drained by an
// external valid/ready consumer; a status word reports occupancy/overflow.
module mmio_out_port
  import mmio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 4,
  parameter logic [31:0] OUT_ADDR    = MMIO_OUT_ADDR,
  parameter logic [31:0] STATUS_ADDR = MMIO_STATUS_ADDR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  hit_out, hit_status;
  logic                  width_ok, push_req, pop_req;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] status;
  logic                  fifo_empty, fifo_full;
  logic [CW-1:0]         fifo_count;
  logic                  overflow_q, overflow_d;

  assign hit_out    = (A == DATA_WIDTH'(OUT_ADDR));
  assign hit_status = (A == DATA_WIDTH'(STATUS_ADDR));
  assign hit        = hit_out || hit_status;

  always_comb begin
    push_data = '0;
    width_ok  = 1'b1;
    case (funct3)
      F3_SW:   push_data = WD;
      F3_SH:   push_data[15:0] = WD[15:0];
      F3_SB:   push_data[7:0]  = WD[7:0];
      default: width_ok = 1'b0;
    endcase
  end

  assign push_req  = WE && hit_out && width_ok;
  assign pop_req   = out_valid && out_ready;
  assign out_valid = !fifo_empty;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop_req),
    .wdata (push_data),
    .rdata (out_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // A simultaneous pop makes room, so only a push into a full, non-draining
  // FIFO is lost and flagged.
  always_comb begin
    overflow_d = overflow_q;
    if (WE && hit_status) begin
      overflow_d = 1'b0;
    end else if (push_req && fifo_full && !pop_req) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    status                      = '0;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_FULL]             = fifo_full;
    status[ST_OVF]              = overflow_q;
    status[ST_CNT_LO +: CW]     = fifo_count;
  end

  assign RD = hit_status ? status : '0;

endmodule

// File: tb/tb_mmio_out_port.sv
// Directed bench for mmio_out_port: a queue of expected words is filled on
// accepted stores and compared against out_data on each handshake.
module tb_mmio_out_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [2:0]  funct3;
  logic [31:0] RD;
  logic        hit;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] OUT_A  = 32'h0000_00F8;
  localparam logic [31:0] STAT_A = 32'h0000_00F4;
  localparam int          DEPTH  = 4;

  always #5 clk = ~clk;

  mmio_out_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .WE        (WE),
    .A         (A),
    .WD        (WD),
    .funct3    (funct3),
    .RD        (RD),
    .hit       (hit),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Compare outputs against the scoreboard, update it for the driven inputs,
  // then advance one clock and return at the following negedge.
  task automatic tick();
    logic [31:0] head;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("out_data", out_data, head);
      if (out_ready) void'(exp_q.pop_front());
    end else begin
      chk("out_data_empty", out_data, 32'h0);
    end
    if (!rst_n) begin
      exp_q.delete();
    end else if (WE && A == OUT_A && funct3 inside {3'b000, 3'b001, 3'b010}) begin
      if (exp_q.size() < DEPTH) begin
        case (funct3)
          3'b000:  exp_q.push_back({24'b0, WD[7:0]});
          3'b001:  exp_q.push_back({16'b0, WD[15:0]});
          default: exp_q.push_back(WD);
        endcase
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    WE = 1'b1; A = addr; WD = data; funct3 = f3;
    tick();
    WE = 1'b0; A = 32'h0; WD = 32'h0; funct3 = 3'b010;
  endtask

  task automatic status_is(input string tag, input logic [31:0] expv);
    A = STAT_A;
    #1;
    chk(tag, RD, expv);
    chk({tag, "_hit"}, {31'b0, hit}, 32'h1);
    A = 32'h0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; WE = 1'b0; A = 32'h0; WD = 32'h0; funct3 = 3'b010; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_data", out_data, 32'h0);
    status_is("rst_status", 32'h0000_0001);
    A = OUT_A; #1;
    chk("rd_zero_at_out", RD, 32'h0);
    chk("hit_out", {31'b0, hit}, 32'h1);
    A = 32'h0000_0040; #1;
    chk("hit_miss", {31'b0, hit}, 32'h0);
    A = 32'h0;
    tick();

    // Single sw
    store(OUT_A, 32'hDEAD_BEEF, 3'b010);
    #1;
    chk("sw_valid", {31'b0, out_valid}, 32'h1);
    chk("sw_data", out_data, 32'hDEAD_BEEF);
    status_is("sw_status", 32'h0000_0010);
    tick();
    chk("sw_hold", out_data, 32'hDEAD_BEEF);
    drain(1);
    status_is("sw_empty", 32'h0000_0001);

    // Width extension; unsupported funct3 must not push
    store(OUT_A, 32'h1234_56A5, 3'b000);
    store(OUT_A, 32'h0000_BEEF, 3'b001);
    store(OUT_A, 32'h0000_0099, 3'b011);
    chk("sb_data", out_data, 32'h0000_00A5);
    status_is("ext_status", 32'h0000_0020);
    drain(2);
    status_is("ext_empty", 32'h0000_0001);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) store(OUT_A, i, 3'b010);
    status_is("ovf_status", 32'h0000_0046);
    drain(4);
    status_is("ovf_drained", 32'h0000_0005);
    store(STAT_A, 32'hFFFF_FFFF, 3'b000);
    status_is("ovf_cleared", 32'h0000_0001);

    // Simultaneous push and pop at full
    for (int i = 10; i <= 13; i++) store(OUT_A, i, 3'b010);
    status_is("full_status", 32'h0000_0042);
    out_ready = 1'b1;
    store(OUT_A, 32'd14, 3'b010);
    out_ready = 1'b0;
    status_is("simul_status", 32'h0000_0042);
    chk("simul_head", out_data, 32'd11);
    drain(4);
    status_is("simul_empty", 32'h0000_0001);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) store(OUT_A, 32'h21 + i, 3'b010);
    status_is("pre_rst", 32'h0000_0030);
    rst_n = 1'b0;
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    status_is("mid_rst_status", 32'h0000_0001);
    store(OUT_A, 32'h7, 3'b010);
    chk("post_rst_data", out_data, 32'h7);
    drain(1);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("final_queue", exp_q.size(), 32'h0);
    status_is("final_status", 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_out_port.md
Name: mmio_out_port

Overview:
- Memory-mapped output peripheral. It is the store-side counterpart to the data memory's MMIO trigger input.
- CPU stores to OUT_ADDR push a word into a small FIFO. An external consumer drains the FIFO over a valid/ready handshake.
- A status word at STATUS_ADDR lets software poll occupancy and overflow before storing.
- Sits beside the data memory on the same A/WD/WE/funct3 bus. The top level muxes RD using the hit output.

Parameters:
- DATA_WIDTH, 32, bus and FIFO word width.
- DEPTH, 4, FIFO entries; power of two, 2..8.
- OUT_ADDR, 32'h000000F8, data push address.
- STATUS_ADDR, 32'h000000F4, status read / overflow-clear address.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- WE  in  1  store enable from datapath.
- A  in  DATA_WIDTH  byte address from ALU.
- WD  in  DATA_WIDTH  store data.
- funct3  in  3  load/store width code.
- RD  out  DATA_WIDTH  status read data; 0 unless A==STATUS_ADDR.
- hit  out  1  A==OUT_ADDR or A==STATUS_ADDR (combinational), for the top-level RD mux.
- out_data  out  DATA_WIDTH  head-of-FIFO word; 0 when empty.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst_n==0 at a clk edge):
  - read/write pointers and count go to 0; overflow goes to 0.
  - out_valid=0 and out_data=0 from the next cycle.
  - Reset mid-transfer discards all FIFO contents; no pop is reported.
- Push condition: WE && A==OUT_ADDR. Push data depends on funct3:
  - 010 (sw): WD.
  - 001 (sh): {16'b0, WD[15:0]}.
  - 000 (sb): {24'b0, WD[7:0]}.
  - Any other funct3: no push, no flag change.
- Pop condition: out_valid && out_ready. The head advances at the clock edge.
- FWFT:
  - out_data is combinationally the head entry.
  - A push at edge N is visible as out_valid=1 from cycle N+1 (1-cycle latency).
- Full, push, no pop: the write is dropped, contents unchanged, overflow is set (sticky).
- Full, push and pop in the same cycle: both are accepted. Count is unchanged and overflow is not set.
- Empty, pop attempt: impossible (out_valid=0); out_ready is ignored.
- Empty, push with out_ready=1: no same-cycle bypass. The word appears at N+1.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Status word (RD when A==STATUS_ADDR, independent of funct3; combinational like the data memory read):
  - bit0 = empty, bit1 = full, bit2 = overflow.
  - bits[7:4] = count, zero-extended.
  - all other bits 0.
- Overflow clear: WE && A==STATUS_ADDR (any funct3, any WD) clears overflow at the edge.
  - If the clear coincides with an overflow-causing push: impossible, since the two addresses differ.
- The consumer must hold out_ready meaningfully only when out_valid=1. out_data must stay stable while out_valid=1 and out_ready=0.
- No stalls are ever returned to the CPU. Stores always complete in one cycle.

Decomposition:
- Package mmio_pkg:
  - OUT_ADDR and STATUS_ADDR localparams, plus the existing trigger address 32'h000000FC.
  - funct3 width codes (SB/SH/SW).
  - Status bit index constants.
- Sub-module sync_fifo (DATA_WIDTH, DEPTH):
  - ports: push/pop/wdata/rdata/empty/full/count; same clk/rst_n.
- mmio_out_port contains the address decode, width extension, overflow flag and status mux.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 → out_valid=0, out_data=0, status RD=32'h00000001.
- Single sw: WD=32'hDEADBEEF to 0xF8, out_ready=0 → next cycle out_valid=1, out_data=32'hDEADBEEF, status=32'h00000010. With out_ready=1 one cycle later → empty again.
- Width extension: sb WD=32'h123456A5, then sh WD=32'h0000BEEF, drained → out_data 32'h000000A5, then 32'h0000BEEF.
- Fill and overflow: 5 sw (1..5) with out_ready=0, DEPTH=4 → status=32'h00000046. Drain yields 1,2,3,4; word 5 lost. A store to 0xF4 → overflow bit clears.
- Simultaneous at full: FIFO full with 10..13, sw 14 while out_ready=1 → 10 popped, count stays 4, overflow=0. Drain yields 11,12,13,14.
- Reset mid-operation: 3 words queued, rst_n=0 for one edge → out_valid=0 next cycle, count=0. A subsequent push of 32'h7 is the only word delivered.
